// File: rtl/axi_uart_lite_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_uart_lite_slave_pkg
// Brief   : Register offsets, STAT/CTRL bit indices, AXI responses and FSM
//           state encodings shared by the UART-Lite style AXI slave.
// Revision: 1.0  initial release
// ============================================================================
package axi_uart_lite_slave_pkg;

    localparam logic [1:0] c_reg_rx   = 2'd0;
    localparam logic [1:0] c_reg_tx   = 2'd1;
    localparam logic [1:0] c_reg_stat = 2'd2;
    localparam logic [1:0] c_reg_ctrl = 2'd3;

    localparam int c_stat_rx_valid = 0;
    localparam int c_stat_rx_full  = 1;
    localparam int c_stat_tx_empty = 2;
    localparam int c_stat_tx_full  = 3;
    localparam int c_stat_intr_en  = 4;
    localparam int c_stat_overrun  = 5;

    localparam int c_ctrl_clr_tx  = 0;
    localparam int c_ctrl_clr_rx  = 1;
    localparam int c_ctrl_intr_en = 4;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_uart_lite_slave_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module  : byte_fifo
// Brief   : Synchronous byte FIFO; a pop in the same cycle lets a push into a
//           full FIFO succeed, and clr overrides any push or pop.
// Revision: 1.0  initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       clr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full_count);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{c_aw{1'b0}}, w_do_push} - {{c_aw{1'b0}}, w_do_pop};
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push && !clr) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/axi_uart_lite_slave.sv
`default_nettype none
// ============================================================================
// Module  : axi_uart_lite_slave
// Brief   : AXI4-Lite slave exposing RX/TX byte FIFOs plus STAT and CTRL
//           registers between an AXI-Lite master and a byte-stream UART PHY.
// Revision: 1.0  initial release
// ============================================================================
module axi_uart_lite_slave
    import axi_uart_lite_slave_pkg::*;
#(
    parameter int AXI_ADDRW      = 32,
    parameter int AXI_DATAW      = 32,
    parameter int AXI_DATAW_BYTE = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDRW-1:0]      araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [AXI_DATAW-1:0]      rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic [AXI_ADDRW-1:0]      awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_DATAW-1:0]      wdata,
    input  logic [AXI_DATAW_BYTE-1:0] wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      intr
);

    rd_state_t            r_rd_state, w_rd_next;
    wr_state_t            r_wr_state, w_wr_next;
    logic [AXI_DATAW-1:0] r_rdata, w_rd_data;
    logic [1:0]           r_rresp, w_rd_resp, r_bresp, w_wr_resp;
    logic                 w_ar_hs, w_wr_en, w_stat_clr, w_intr_en_we;
    logic                 w_rx_pop, w_rx_clr, w_rx_empty, w_rx_full, w_rx_overrun;
    logic                 w_tx_push, w_tx_pop, w_tx_clr, w_tx_empty, w_tx_full;
    logic [7:0]           w_rx_dout;
    logic                 r_overrun, r_intr_en, r_intr, r_rx_empty_d, r_tx_empty_d;
    logic                 w_unused_ok;

    assign w_unused_ok = ^{arprot, awprot, araddr[AXI_ADDRW-1:4], araddr[1:0],
                           awaddr[AXI_ADDRW-1:4], awaddr[1:0],
                           wdata[AXI_DATAW-1:8], wstrb[AXI_DATAW_BYTE-1:1]};

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_valid), .pop(w_rx_pop), .clr(w_rx_clr),
        .din(rx_data), .dout(w_rx_dout), .empty(w_rx_empty), .full(w_rx_full)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop), .clr(w_tx_clr),
        .din(wdata[7:0]), .dout(tx_data), .empty(w_tx_empty), .full(w_tx_full)
    );

    assign tx_valid = ~w_tx_empty;
    assign w_tx_pop = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        arready   = 1'b0;
        rvalid    = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rd_next = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_next = r_wr_state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (r_wr_state)
            W_IDLE: if (awvalid && wvalid) w_wr_next = W_ACK;
            W_ACK: begin
                awready   = 1'b1;
                wready    = 1'b1;
                w_wr_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    assign w_ar_hs = arready & arvalid;
    assign w_wr_en = (r_wr_state == W_ACK);

    always_comb begin
        w_rd_data  = '0;
        w_rd_resp  = c_resp_okay;
        w_rx_pop   = 1'b0;
        w_stat_clr = 1'b0;
        case (araddr[3:2])
            c_reg_rx: begin
                if (w_rx_empty) begin
                    w_rd_resp = c_resp_slverr;
                end else begin
                    w_rd_data[7:0] = w_rx_dout;
                    w_rx_pop       = w_ar_hs;
                end
            end
            c_reg_stat: begin
                w_rd_data[c_stat_rx_valid] = ~w_rx_empty;
                w_rd_data[c_stat_rx_full]  = w_rx_full;
                w_rd_data[c_stat_tx_empty] = w_tx_empty;
                w_rd_data[c_stat_tx_full]  = w_tx_full;
                w_rd_data[c_stat_intr_en]  = r_intr_en;
                w_rd_data[c_stat_overrun]  = r_overrun;
                w_stat_clr                 = w_ar_hs;
            end
            default: w_rd_resp = c_resp_slverr;
        endcase
    end

    always_comb begin
        w_tx_push    = 1'b0;
        w_tx_clr     = 1'b0;
        w_rx_clr     = 1'b0;
        w_intr_en_we = 1'b0;
        w_wr_resp    = c_resp_okay;
        if (w_wr_en) begin
            case (awaddr[3:2])
                c_reg_tx: begin
                    // A PHY pop in the same cycle makes room for the push.
                    if (wstrb[0]) begin
                        if (w_tx_full && !w_tx_pop) w_wr_resp = c_resp_slverr;
                        else                        w_tx_push = 1'b1;
                    end
                end
                c_reg_ctrl: begin
                    w_tx_clr     = wdata[c_ctrl_clr_tx];
                    w_rx_clr     = wdata[c_ctrl_clr_rx];
                    w_intr_en_we = 1'b1;
                end
                default: w_wr_resp = c_resp_slverr;
            endcase
        end
    end

    assign w_rx_overrun = rx_valid & w_rx_full & ~w_rx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata      <= '0;
            r_rresp      <= c_resp_okay;
            r_bresp      <= c_resp_okay;
            r_overrun    <= 1'b0;
            r_intr_en    <= 1'b0;
            r_intr       <= 1'b0;
            r_rx_empty_d <= 1'b1;
            r_tx_empty_d <= 1'b1;
        end else begin
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
            if (w_wr_en) r_bresp <= w_wr_resp;
            if (w_rx_overrun)    r_overrun <= 1'b1;
            else if (w_stat_clr) r_overrun <= 1'b0;
            if (w_intr_en_we) r_intr_en <= wdata[c_ctrl_intr_en];
            r_rx_empty_d <= w_rx_empty;
            r_tx_empty_d <= w_tx_empty;
            r_intr <= r_intr_en & ((r_rx_empty_d & ~w_rx_empty) | (~r_tx_empty_d & w_tx_empty));
        end
    end

    assign rdata = r_rdata;
    assign rresp = r_rresp;
    assign bresp = r_bresp;
    assign intr  = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_axi_uart_lite_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_uart_lite_slave
// Brief   : Directed bench for axi_uart_lite_slave: vector table plus
//           hand-written multi-cycle sequences.
// Revision: 1.0  initial release
// ============================================================================
module tb_axi_uart_lite_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int OP_RX = 0, OP_RD = 1, OP_WR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic [2:0]  arprot = '0, awprot = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic [1:0]  rresp, bresp;
    logic [7:0]  rx_data = '0, tx_data;
    logic        rx_valid = 0, tx_valid, tx_ready = 0, intr;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int intr_cnt = 0;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;
    vec_t vq[$];

    axi_uart_lite_slave dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .intr(intr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awready && wready) hs_cnt <= hs_cnt + 1;
        if (intr)              intr_cnt <= intr_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0; n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (!rvalid) check("rd_timeout", 32'(rvalid), 32'd1);
        d = rdata; r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit pop_in_ack, output logic [1:0] r);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) check("aw_timeout", 32'(awready), 32'd1);
        if (pop_in_ack) tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) check("b_timeout", 32'(bvalid), 32'd1);
        r = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic add(input int op, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er,
                       input string nm);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.strb = s;
        v.exp_data = ed; v.exp_resp = er; v.name = nm;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  got[$];
        int          n, h0, i0, bad;

        add(OP_RD, 32'h8,    0, 0, 32'h04, OKAY,   "stat_reset");
        add(OP_RX, 0,      'h41, 0, 0,     OKAY,   "rx41");
        add(OP_RD, 32'h8,    0, 0, 32'h05, OKAY,   "stat_rx1");
        add(OP_RD, 32'h0,    0, 0, 32'h41, OKAY,   "rx_pop");
        add(OP_RD, 32'h8,    0, 0, 32'h04, OKAY,   "stat_after_pop");
        add(OP_RD, 32'h0,    0, 0, 32'h00, SLVERR, "rx_empty");
        add(OP_RD, 32'h4,    0, 0, 32'h00, SLVERR, "rd_tx");
        add(OP_RD, 32'hC,    0, 0, 32'h00, SLVERR, "rd_ctrl");
        add(OP_WR, 32'h0, 'h12, 4'hF, 0,   SLVERR, "wr_rx");
        add(OP_WR, 32'h8, 'h00, 4'hF, 0,   SLVERR, "wr_stat");
        add(OP_WR, 32'h4, 'h99, 4'hE, 0,   OKAY,   "tx_nostrb");
        add(OP_RD, 32'h8,    0, 0, 32'h04, OKAY,   "stat_no_push");
        add(OP_RX, 0,      'h7E, 0, 0,     OKAY,   "rx7e");
        add(OP_RX, 0,      'h33, 0, 0,     OKAY,   "rx33");
        add(OP_RD, 32'h0,    0, 0, 32'h7E, OKAY,   "rx_first");
        add(OP_RD, 32'h0,    0, 0, 32'h33, OKAY,   "rx_second");
        add(OP_RD, 32'h1008, 0, 0, 32'h04, OKAY,   "stat_alias");

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_arready", 32'(arready), 1);
        check("rst_awready", 32'(awready), 0);
        check("rst_wready",  32'(wready),  0);
        check("rst_rvalid",  32'(rvalid),  0);
        check("rst_bvalid",  32'(bvalid),  0);
        check("rst_rdata",   rdata,        0);
        check("rst_resp",    32'({rresp, bresp}), 0);
        check("rst_tx_intr", 32'({tx_valid, intr}), 0);

        foreach (vq[k]) begin
            case (vq[k].op)
                OP_RX: rx_push(vq[k].data[7:0]);
                OP_RD: begin
                    axi_read(vq[k].addr, d, r);
                    check({vq[k].name, "_data"}, d, vq[k].exp_data);
                    check({vq[k].name, "_resp"}, 32'(r), 32'(vq[k].exp_resp));
                end
                default: begin
                    axi_write(vq[k].addr, vq[k].data, vq[k].strb, 1'b0, r);
                    check({vq[k].name, "_resp"}, 32'(r), 32'(vq[k].exp_resp));
                end
            endcase
        end

        // RX overflow: 17 bytes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) rx_push(8'(i));
        axi_read(32'h8, d, r); check("stat_overrun", d, 32'h27);
        axi_read(32'h8, d, r); check("stat_overrun_clr", d, 32'h07);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h0, d, r);
            if (d !== 32'(i) || r !== OKAY) bad++;
        end
        check("rx_16_bytes_bad", 32'(bad), 0);
        axi_read(32'h8, d, r); check("stat_rx_drained", d, 32'h04);

        // TX push and PHY pop.
        axi_write(32'h4, 32'h5A, 4'h1, 1'b0, r);
        check("tx_wr_resp", 32'(r), 32'(OKAY));
        check("tx_valid_set", 32'(tx_valid), 1);
        check("tx_data", 32'(tx_data), 32'h5A);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_valid_clr", 32'(tx_valid), 0);

        // TX full, overflow, then push with a simultaneous PHY pop.
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            axi_write(32'h4, 32'h10 + 32'(i), 4'h1, 1'b0, r);
            if (r !== OKAY) bad++;
        end
        check("tx_fill_bad", 32'(bad), 0);
        axi_write(32'h4, 32'hEE, 4'h1, 1'b0, r);
        check("tx_full_resp", 32'(r), 32'(SLVERR));
        axi_read(32'h8, d, r); check("stat_tx_full", d, 32'h08);
        axi_write(32'h4, 32'hAA, 4'h1, 1'b1, r);
        check("tx_full_pop_resp", 32'(r), 32'(OKAY));
        axi_read(32'h8, d, r); check("stat_tx_still_full", d, 32'h08);
        tx_ready = 1'b1; n = 0;
        while (tx_valid && n < 40) begin got.push_back(tx_data); @(negedge clk); n++; end
        tx_ready = 1'b0;
        check("tx_drain_count", 32'(got.size()), 16);
        if (got.size() == 16) begin
            check("tx_drain_first", 32'(got[0]), 32'h11);
            check("tx_drain_last",  32'(got[15]), 32'hAA);
        end

        // Interrupts and FIFO clear.
        axi_write(32'hC, 32'h10, 4'hF, 1'b0, r);
        check("ctrl_en_resp", 32'(r), 32'(OKAY));
        i0 = intr_cnt;
        rx_push(8'h55);
        repeat (6) @(negedge clk);
        check("intr_rx_pulses", 32'(intr_cnt - i0), 1);
        axi_write(32'h4, 32'h66, 4'h1, 1'b0, r);
        i0 = intr_cnt;
        axi_write(32'hC, 32'h13, 4'hF, 1'b0, r);
        repeat (4) @(negedge clk);
        check("intr_tx_clear", 32'(intr_cnt - i0), 1);
        axi_read(32'h8, d, r); check("stat_cleared", d, 32'h14);
        axi_write(32'hC, 32'h00, 4'hF, 1'b0, r);
        axi_read(32'h8, d, r); check("stat_intr_off", d, 32'h04);

        // awvalid ahead of wvalid, and bready held low.
        awaddr = 32'hC; wdata = 0; wstrb = 4'hF; awvalid = 1'b1; bad = 0;
        h0 = hs_cnt;
        repeat (2) begin @(negedge clk); if (awready || wready) bad++; end
        check("aw_early_no_ready", 32'(bad), 0);
        wvalid = 1'b1; n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("aw_w_together", 32'({awready, wready}), 32'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bad = 0;
        repeat (5) begin if (!bvalid) bad++; @(negedge clk); end
        check("bvalid_held", 32'(bad), 0);
        check("hs_once", 32'(hs_cnt - h0), 1);
        check("b_hold_resp", 32'(bresp), 32'(OKAY));
        bready = 1'b1; @(negedge clk); bready = 1'b0;
        check("bvalid_dropped", 32'(bvalid), 0);

        // Reset abandons an outstanding read.
        araddr = 32'h8; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("rd_pending", 32'(rvalid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rd_abandoned", 32'({rvalid, arready}), 32'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
